// File: rtl/lcd_pkg.sv
// lcd_pkg: command codes, blank character and FSM encoding shared by the LCD responder.
package lcd_pkg;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPCTL = 8'h08;
  localparam logic [7:0] CMD_SETADDR = 8'h80;
  localparam logic [7:0] BLANK_CHAR  = 8'h20;
  typedef enum logic [1:0] {IDLE, CLEAR, WAIT} state_t;
endpackage

// File: rtl/lcd_ram.sv
// lcd_ram: DEPTH x 8 display RAM, synchronous write, async core and view read ports.
module lcd_ram #(
  parameter int DEPTH = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata,
  input  logic [ADDR_W-1:0] vaddr,
  output logic [7:0]        vdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
  assign vdata = mem[vaddr];
endmodule

// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-style display controller answering CPU wr/rd strobes on the iobus.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int SHORT_CYCLES = 4,
  parameter int CLEAR_CYCLES = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic              cmd,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              dout_en,
  output logic              busy,
  output logic              overrun,
  output logic              disp_on,
  input  logic [ADDR_W-1:0] view_addr,
  output logic [7:0]        view_char
);
  localparam int CNT_W = $clog2(CLEAR_CYCLES + SHORT_CYCLES + 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, clr_q, clr_d, step, waddr;
  logic inc_q, inc_d, disp_q, disp_d, ovr_q, ovr_d, wr_q, rd_q, wr_ev, rd_ev, we;
  logic [7:0] dout_q, dout_d, wdata, rdata;
  assign wr_ev = wr & ~wr_q;
  assign rd_ev = rd & ~rd_q;
  assign busy = state_q != IDLE;
  assign step = inc_q ? addr_q + 1'b1 : addr_q - 1'b1;
  assign dout = dout_q;
  assign dout_en = rd;
  assign overrun = ovr_q;
  assign disp_on = disp_q;

  lcd_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(addr_q), .rdata(rdata), .vaddr(view_addr), .vdata(view_char)
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    clr_d = clr_q;
    inc_d = inc_q;
    disp_d = disp_q;
    ovr_d = ovr_q | (wr_ev & busy);
    dout_d = dout_q;
    we = 1'b0;
    waddr = addr_q;
    wdata = din;
    // Reads see pre-write state; an accepted write owns the address update.
    if (rd_ev)
      dout_d = cmd ? {busy, 7'(addr_q)} : (busy ? 8'h00 : rdata);
    if (rd_ev && !cmd && !busy && !wr_ev) addr_d = step;
    unique case (state_q)
      IDLE: if (wr_ev) begin
        state_d = WAIT;
        cnt_d = CNT_W'(SHORT_CYCLES - 1);
        if (!cmd) begin
          we = 1'b1;
          addr_d = step;
        end else if (|(din & CMD_SETADDR)) addr_d = din[ADDR_W-1:0];
        else if (|(din & CMD_DISPCTL)) disp_d = din[2];
        else if (|(din & CMD_ENTRY)) inc_d = din[1];
        else if (|(din & CMD_HOME)) begin
          addr_d = '0;
          cnt_d = CNT_W'(CLEAR_CYCLES - 1);
        end else if (|(din & CMD_CLEAR)) begin
          state_d = CLEAR;
          clr_d = '0;
          addr_d = '0;
          inc_d = 1'b1;
        end
      end
      CLEAR: begin
        we = 1'b1;
        waddr = clr_q;
        wdata = BLANK_CHAR;
        clr_d = clr_q + 1'b1;
        if (clr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = (CLEAR_CYCLES == DEPTH) ? IDLE : WAIT;
          cnt_d = CNT_W'(CLEAR_CYCLES - DEPTH - 1);
        end
      end
      WAIT: begin
        state_d = (cnt_q == '0) ? IDLE : WAIT;
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      clr_q <= '0;
      inc_q <= 1'b1;
      disp_q <= 1'b0;
      ovr_q <= 1'b0;
      dout_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      clr_q <= clr_d;
      inc_q <= inc_d;
      disp_q <= disp_d;
      ovr_q <= ovr_d;
      dout_q <= dout_d;
      wr_q <= wr;
      rd_q <= rd;
    end
  end
endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: table-driven and hand-sequenced checks of lcd_responder through a scoreboard queue.
module tb_lcd_responder;
  logic clk = 1'b0, rst = 1'b0, wr = 1'b0, rd = 1'b0, cmd = 1'b0;
  logic [7:0] din = 8'h00, dout, view_char;
  logic dout_en, busy, overrun, disp_on;
  logic [4:0] view_addr = 5'd0;
  int n_chk = 0, n_pass = 0, blen;

  lcd_responder #(.DEPTH(32), .SHORT_CYCLES(4), .CLEAR_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .cmd(cmd), .din(din), .dout(dout),
    .dout_en(dout_en), .busy(busy), .overrun(overrun), .disp_on(disp_on),
    .view_addr(view_addr), .view_char(view_char)
  );

  always #5 clk = ~clk;

  typedef struct {string name; logic [7:0] exp;} exp_t;
  exp_t sb[$];

  typedef struct {logic c; logic [7:0] d; int bl; logic [7:0] st; int va; logic [7:0] vc;} vec_t;
  vec_t tbl[12];

  task automatic push(string nm, logic [7:0] e);
    sb.push_back('{nm, e});
  endtask

  task automatic retire(logic [7:0] got);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: got %02h with nothing expected", got);
      return;
    end
    e = sb.pop_front();
    if (got === e.exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", e.name, got, e.exp);
  endtask

  task automatic view(int a, logic [7:0] e, string nm);
    push(nm, e);
    view_addr = 5'(a);
    #1;
    retire(view_char);
  endtask

  task automatic rd_op(logic c, logic [7:0] e, string nm);
    push(nm, e);
    @(negedge clk);
    cmd = c;
    rd = 1'b1;
    @(negedge clk);
    retire(dout);
    push({nm, "_en"}, 8'h01);
    retire({7'b0, dout_en});
    rd = 1'b0;
    @(negedge clk);
    push({nm, "_hold"}, e);
    retire(dout);
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    push(nm, 8'h00);
    retire({7'b0, busy});
  endtask

  task automatic wr_op(logic c, logic [7:0] d, output int bl);
    @(negedge clk);
    cmd = c;
    din = d;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    bl = 0;
    while (busy && bl < 300) begin
      bl++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 8'h48, 4,  8'h01, 0,  8'h48};
    tbl[1]  = '{1'b0, 8'h69, 4,  8'h02, 1,  8'h69};
    tbl[2]  = '{1'b1, 8'h9F, 4,  8'h1F, 1,  8'h69};
    tbl[3]  = '{1'b0, 8'h41, 4,  8'h00, 31, 8'h41};
    tbl[4]  = '{1'b0, 8'h42, 4,  8'h01, 0,  8'h42};
    tbl[5]  = '{1'b1, 8'h04, 4,  8'h01, 0,  8'h42};
    tbl[6]  = '{1'b1, 8'h80, 4,  8'h00, 0,  8'h42};
    tbl[7]  = '{1'b0, 8'h5A, 4,  8'h1F, 0,  8'h5A};
    tbl[8]  = '{1'b1, 8'h06, 4,  8'h1F, 31, 8'h41};
    tbl[9]  = '{1'b1, 8'h0C, 4,  8'h1F, 1,  8'h69};
    tbl[10] = '{1'b1, 8'h02, 64, 8'h00, 0,  8'h5A};
    tbl[11] = '{1'b1, 8'h00, 4,  8'h00, 31, 8'h41};

    repeat (3) @(negedge clk);
    push("rst_busy", 8'h00);    retire({7'b0, busy});
    push("rst_overrun", 8'h00); retire({7'b0, overrun});
    push("rst_disp_on", 8'h00); retire({7'b0, disp_on});
    push("rst_dout", 8'h00);    retire(dout);
    push("rst_dout_en", 8'h00); retire({7'b0, dout_en});
    rst = 1'b1;
    rd_op(1'b1, 8'h00, "rst_status");

    for (int i = 0; i < 12; i++) begin
      wr_op(tbl[i].c, tbl[i].d, blen);
      push($sformatf("row%0d_busy_len", i), 8'(tbl[i].bl));
      retire(8'(blen));
      rd_op(1'b1, tbl[i].st, $sformatf("row%0d_status", i));
      view(tbl[i].va, tbl[i].vc, $sformatf("row%0d_view", i));
    end
    push("disp_on_set", 8'h01);
    retire({7'b0, disp_on});

    wr_op(1'b1, 8'h01, blen);
    push("clear_busy_len", 8'd64);
    retire(8'(blen));
    for (int k = 0; k < 32; k++) view(k, 8'h20, $sformatf("clear_view%0d", k));
    rd_op(1'b1, 8'h00, "clear_status");

    // Second write lands inside the busy window of the first.
    @(negedge clk); cmd = 1'b0; din = 8'h11; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    @(negedge clk); din = 8'h55; wr = 1'b1;
    @(negedge clk); wr = 1'b0; cmd = 1'b1; rd = 1'b1;
    push("busy_status", 8'h81);
    @(negedge clk); retire(dout); rd = 1'b0;
    wait_idle("ovr_idle");
    push("overrun_set", 8'h01);
    retire({7'b0, overrun});
    view(0, 8'h11, "ovr_ram0");
    view(1, 8'h20, "ovr_ram1");
    rd_op(1'b1, 8'h01, "ovr_status");

    @(negedge clk); cmd = 1'b0; din = 8'h22; wr = 1'b1;
    @(negedge clk); wr = 1'b0; rd = 1'b1;
    push("busy_data_rd", 8'h00);
    @(negedge clk); retire(dout); rd = 1'b0;
    wait_idle("bdr_idle");
    rd_op(1'b1, 8'h02, "bdr_status");
    wr_op(1'b1, 8'h81, blen);
    rd_op(1'b0, 8'h22, "data_rd");
    rd_op(1'b1, 8'h02, "data_rd_status");

    wr_op(1'b1, 8'h85, blen);
    @(negedge clk); cmd = 1'b0; din = 8'h33; wr = 1'b1;
    repeat (10) @(negedge clk);
    wr = 1'b0;
    wait_idle("hold_idle");
    view(5, 8'h33, "hold_ram5");
    view(6, 8'h20, "hold_ram6");
    rd_op(1'b1, 8'h06, "hold_status");

    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lcd_responder.md
Name: lcd_responder

Overview:
- Synthesizable HD44780-style character display controller.
- Sits on the 8-bit iobus as the responder to the CPU's LCD strobes (wr/cmd) and busy/data reads (rd).
- Holds a DEPTH-byte display RAM, an address counter with entry-mode direction, and busy timing.
- Used as the real display model in board-level simulation and as a synthesizable display front-end.

Parameters:
DEPTH, 32, display RAM size in characters; must be a power of 2; ADDR_W = log2(DEPTH), at most 7.
SHORT_CYCLES, 4, busy duration after any data write or short command.
CLEAR_CYCLES, 64, minimum busy duration after clear/home; must be >= DEPTH.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-low
wr  input  1  write strobe, level; acted on at its rising edge as sampled by clk
rd  input  1  read strobe, level; acted on at its rising edge; dout held while high
cmd  input  1  1 = command/status register, 0 = data register
din  input  8  write data
dout  output  8  read data
dout_en  output  1  high while rd is high; drives the iobus buffer
busy  output  1  busy flag
overrun  output  1  sticky: a write arrived while busy
disp_on  output  1  display-enable bit from display control command
view_addr  input  ADDR_W  asynchronous debug read address into display RAM
view_char  output  8  display RAM contents at view_addr, combinational

Behaviour:
- Reset (rst low, asynchronous):
  - address counter = 0; increment mode = 1; disp_on = 0.
  - busy = 0; overrun = 0; dout = 0; state = IDLE.
  - Display RAM is not reset; it is cleared only by command 0x01.
- Edge detection: registered wr_q/rd_q. A write event is wr & ~wr_q; a read event is rd & ~rd_q. One event per strobe, however long the strobe is held.
- Write while busy: ignored, no state change, overrun set to 1. overrun clears only on reset.
- Command decode (cmd=1, write event, not busy), highest set bit wins:
  - 0x80|a: address = a mod DEPTH; short busy.
  - 0x08-0x0F: disp_on = din[2]; short busy.
  - 0x04-0x07: increment mode = din[1] (1 = +1, 0 = -1); short busy.
  - 0x02: address = 0; busy for CLEAR_CYCLES.
  - 0x01: enter CLEAR; address = 0; increment mode = 1.
  - 0x00: no effect; short busy.
- Data write (cmd=0, write event, not busy):
  - RAM[address] = din, then address moves +/-1 modulo DEPTH.
  - Wrap cases: DEPTH-1 -> 0 on +1; 0 -> DEPTH-1 on -1.
  - Short busy.
- Read event, cmd=1: dout = {busy, address zero-extended to 7 bits}, sampled on the event cycle. Reads are allowed while busy.
- Read event, cmd=0:
  - If not busy: dout = RAM[address], address advances per mode, no busy.
  - If busy: dout = 0, address unchanged, overrun unchanged.
- dout_en = rd, combinational. dout holds its last value between reads.
- FSM states: IDLE, CLEAR, WAIT.
  - IDLE -> WAIT on a short op or home: counter = duration-1; busy asserts the cycle after the event.
  - IDLE -> CLEAR on 0x01: writes 0x20 to RAM[k] at cycles k = 0..DEPTH-1, then -> WAIT with counter = CLEAR_CYCLES-DEPTH-1.
    - If CLEAR_CYCLES == DEPTH, CLEAR returns directly to IDLE.
  - WAIT: decrement the counter; at 0 -> IDLE.
  - busy = (state != IDLE).
- Total busy lengths: exactly SHORT_CYCLES cycles for short ops; exactly CLEAR_CYCLES cycles for clear/home.
- Simultaneous wr and rd events: the write is processed; the read still captures status/data from before the write.
- Reset mid-CLEAR aborts the clear; RAM is left partially cleared.

Decomposition:
- Shared package lcd_pkg holds:
  - command codes: CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISPCTL, CMD_SETADDR;
  - the 0x20 blank character;
  - state encoding: IDLE, CLEAR, WAIT.
- One sub-module, lcd_ram: DEPTH x 8 with synchronous write, one asynchronous read port for core use, and one asynchronous read port for view.

Test Plan:
- Reset, then write 0x48 then 0x69 (cmd=0), waiting for busy low between them -> view RAM[0]=0x48, RAM[1]=0x69; status read returns 0x02.
- Clear with DEPTH=32, CLEAR_CYCLES=64 -> busy high for exactly 64 cycles; all 32 view locations read 0x20; address 0.
- Set address 0x9F, write 0x41, write 0x42 -> RAM[31]=0x41, RAM[0]=0x42 (wrap); status read returns 0x01 once not busy.
- Entry 0x04, set address 0x80, write 0x5A -> RAM[0]=0x5A; address becomes 31.
- Write 0x55 one cycle after a data write (still busy) -> ignored; RAM unchanged; overrun=1; status read during busy has bit7=1.
- Hold wr high 10 cycles with data 0x33 -> exactly one RAM write; address advances by exactly 1.
